// File: rtl/fb_rd_ctrl_if.sv
// Frame-buffer read controller bundle: scan request/status, memory read port and pixel stream.
// The master side is the controller; the slave side is the memory plus downstream sink.
interface fb_rd_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] px_data;
    logic                  px_valid;
    logic                  px_ready;
    logic                  px_last;

    modport master (
        input  start,
        output busy,
        output done,
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output px_data,
        output px_valid,
        input  px_ready,
        output px_last
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  px_data,
        input  px_valid,
        output px_ready,
        input  px_last
    );
endinterface

// File: rtl/fb_rd_ctrl.sv
// Scans one frame out of a 1-cycle-latency memory into a ready/valid pixel stream
// through a 2-entry output FIFO, never holding more reads than the FIFO can absorb.
module fb_rd_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int FRAME_LEN  = 2**ADDR_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    fb_rd_ctrl_if.master bus
);
    localparam int               CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      issue_cnt;
    logic                  in_flight;
    logic                  in_flight_last;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_cnt;
    logic                  done_q;
    logic                  rd_en;
    logic                  push, pop;
    logic                  fifo_nonempty;
    logic                  head_last;
    logic [2:0]            committed;

    assign fifo_nonempty = (fifo_cnt != 2'd0);
    assign push          = in_flight;
    assign pop           = fifo_nonempty && bus.px_ready;
    assign head_last     = fifo_last[rd_ptr];
    // Slots already spoken for next cycle: what stays in the FIFO plus the read still in flight.
    assign committed     = 3'(fifo_cnt) - 3'(pop) + 3'(in_flight);

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) state_next = READ;
            end
            READ: begin
                rd_en = (issue_cnt < FRAME_CNT) && (committed < 3'd2);
                if (rd_en && (issue_cnt == LAST_IDX)) state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && head_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            issue_cnt      <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            fifo_cnt       <= 2'd0;
            done_q         <= 1'b0;
        end else begin
            state          <= state_next;
            done_q         <= (state == DRAIN) && pop && head_last;
            in_flight      <= rd_en;
            in_flight_last <= rd_en && (issue_cnt == LAST_IDX);

            if ((state == IDLE) && bus.start) issue_cnt <= '0;
            else if (rd_en)                   issue_cnt <= issue_cnt + CNT_W'(1);

            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;

            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; its contents are only visible through the occupancy-gated outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.mem_rd_data;
            fifo_last[wr_ptr] <= in_flight_last;
        end
    end

    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = issue_cnt[ADDR_WIDTH-1:0];
    assign bus.px_valid    = fifo_nonempty;
    assign bus.px_data     = fifo_nonempty ? fifo_data[rd_ptr] : '0;
    assign bus.px_last     = fifo_nonempty && head_last;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
endmodule

// File: tb/tb_fb_rd_ctrl.sv
// Directed bench for fb_rd_ctrl: an 8-word-frame instance and a 1-word-frame instance,
// each fed by a 1-cycle-latency memory holding addr n = n+1.
module tb_fb_rd_ctrl;
    localparam int DW = 16;
    localparam int AW = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_err    = 0;
    int   n_checks = 0;

    fb_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
    fb_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_if ();

    fb_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.master)
    );

    fb_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_if.mem_rd_en) a_if.mem_rd_data <= DW'(a_if.mem_rd_addr) + DW'(1);
        if (b_if.mem_rd_en) b_if.mem_rd_data <= DW'(b_if.mem_rd_addr) + DW'(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, ".mem_rd_en"},   32'(a_if.mem_rd_en),   0);
        check({tag, ".mem_rd_addr"}, 32'(a_if.mem_rd_addr), 0);
        check({tag, ".px_valid"},    32'(a_if.px_valid),    0);
        check({tag, ".px_last"},     32'(a_if.px_last),     0);
        check({tag, ".px_data"},     32'(a_if.px_data),     0);
        check({tag, ".busy"},        32'(a_if.busy),        0);
        check({tag, ".done"},        32'(a_if.done),        0);
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,1,0...; mode 2: ready 0 for 10 cycles after start.
    // Sample index n=0 is the cycle start is driven; n=k is k cycles after the start edge.
    task automatic run_stream(input int mode, input bit repulse, input string tag);
        int n = 0;
        int issued = 0;
        int xfers = 0;
        int dones = 0;
        int last_n = -1;
        int done_n = -1;
        int first_valid_n = -1;
        bit pulsed = 1'b0;
        bit pop;
        while (n < 80 && !(dones > 0 && n > done_n + 3)) begin
            @(negedge clk);
            a_if.start = (n == 0);
            if (repulse && !pulsed && xfers == 3) begin
                a_if.start = 1'b1;
                pulsed = 1'b1;
            end
            case (mode)
                1:       a_if.px_ready = (n % 2 == 0);
                2:       a_if.px_ready = (n > 10);
                default: a_if.px_ready = 1'b1;
            endcase
            #1;
            pop = a_if.px_valid && a_if.px_ready;
            if (mode == 2 && n == 10) begin
                check({tag, ".stall_reads"}, 32'(issued), 2);
                check({tag, ".stall_data"},  32'(a_if.px_data), 1);
                check({tag, ".stall_valid"}, 32'(a_if.px_valid), 1);
            end
            if (a_if.px_valid && first_valid_n < 0) first_valid_n = n;
            if (a_if.mem_rd_en) begin
                check({tag, ".rd_addr"}, 32'(a_if.mem_rd_addr), 32'(issued));
                check({tag, ".no_overissue"}, 32'((issued - xfers - int'(pop)) < 2), 1);
                issued++;
            end
            if (pop) begin
                check({tag, ".px_data"}, 32'(a_if.px_data), 32'(xfers + 1));
                check({tag, ".px_last"}, 32'(a_if.px_last), 32'(xfers == 7));
                xfers++;
                last_n = n;
            end
            if (a_if.done) begin
                check({tag, ".done_after_last"}, 32'(n), 32'(last_n + 1));
                check({tag, ".busy_at_done"}, 32'(a_if.busy), 0);
                dones++;
                done_n = n;
            end
            n++;
        end
        a_if.start = 1'b0;
        check({tag, ".words"}, 32'(xfers), 8);
        check({tag, ".reads"}, 32'(issued), 8);
        check({tag, ".dones"}, 32'(dones), 1);
        if (mode == 0) begin
            check({tag, ".first_valid_n"}, 32'(first_valid_n), 3);
            check({tag, ".done_n"}, 32'(done_n), 11);
        end
    endtask

    initial begin
        a_if.start    = 1'b0;
        a_if.px_ready = 1'b1;
        b_if.start    = 1'b0;
        b_if.px_ready = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        check_reset_a("reset_a");
        check("reset_b.px_valid", 32'(b_if.px_valid), 0);
        check("reset_b.busy",     32'(b_if.busy),     0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Full-rate frame, backpressured frames, ignored re-start
        run_stream(0, 1'b0, "stream");
        run_stream(1, 1'b0, "toggle");
        run_stream(2, 1'b0, "stall");
        run_stream(0, 1'b1, "repulse");

        // Reset after the 4th transfer
        @(negedge clk);
        a_if.start    = 1'b1;
        a_if.px_ready = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            a_if.start = 1'b0;
            #1;
        end
        check("midrst.word4", 32'(a_if.px_data), 4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_a("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            check("postrst.px_valid", 32'(a_if.px_valid), 0);
            check("postrst.rd_en",    32'(a_if.mem_rd_en), 0);
        end
        run_stream(0, 1'b0, "restart");

        // FRAME_LEN=1, then start coincident with done
        @(negedge clk);
        b_if.start = 1'b1;
        b_if.px_ready = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        #1;
        check("len1.n1.rd_en", 32'(b_if.mem_rd_en),   1);
        check("len1.n1.addr",  32'(b_if.mem_rd_addr), 0);
        check("len1.n1.busy",  32'(b_if.busy),        1);
        @(negedge clk);
        #1;
        check("len1.n2.rd_en", 32'(b_if.mem_rd_en), 0);
        check("len1.n2.valid", 32'(b_if.px_valid),  0);
        @(negedge clk);
        #1;
        check("len1.n3.valid", 32'(b_if.px_valid),  1);
        check("len1.n3.last",  32'(b_if.px_last),   1);
        check("len1.n3.data",  32'(b_if.px_data),   1);
        check("len1.n3.rd_en", 32'(b_if.mem_rd_en), 0);
        @(negedge clk);
        b_if.start = 1'b1;
        #1;
        check("len1.n4.done",  32'(b_if.done),     1);
        check("len1.n4.busy",  32'(b_if.busy),     0);
        check("len1.n4.valid", 32'(b_if.px_valid), 0);
        @(negedge clk);
        b_if.start = 1'b0;
        #1;
        check("coinc.busy",  32'(b_if.busy),        1);
        check("coinc.rd_en", 32'(b_if.mem_rd_en),   1);
        check("coinc.addr",  32'(b_if.mem_rd_addr), 0);
        check("coinc.done",  32'(b_if.done),        0);
        repeat (2) @(negedge clk);
        #1;
        check("coinc.data", 32'(b_if.px_data), 1);
        @(negedge clk);
        #1;
        check("coinc.done2", 32'(b_if.done), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
